// File: rtl/glob_bank_pkg.sv
// Shared types, constants and the reset-value helper for the glob_bank register bank.
package glob_bank_pkg;

    localparam int ERRW = 16;
    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_CHECK = 2'd2,
        OP_SWEEP = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Reset value of channel i: (initval + i*stride) truncated to width bits.
    function automatic logic [MAXW-1:0] init_val(
        input logic [MAXW-1:0] initval,
        input logic [MAXW-1:0] stride,
        input int unsigned     i,
        input int unsigned     width
    );
        logic [MAXW-1:0] full;
        logic [MAXW-1:0] mask;
        full = initval + stride * MAXW'(i);
        mask = (width >= MAXW) ? '1 : ((MAXW'(1) << width) - MAXW'(1));
        return full & mask;
    endfunction

endpackage

// File: rtl/glob_bank_sweep.sv
// Self-check sweep engine: walks every channel once, counting those that
// no longer hold their reset value, then presents the tally for one cycle.
module glob_bank_sweep
    import glob_bank_pkg::*;
#(
    parameter int          NCHAN   = 4,
    parameter int          WIDTH   = 32,
    parameter logic [31:0] INITVAL = 32'hf00d,
    parameter int          STRIDE  = 1,
    localparam int         IDXW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int         TALW    = $clog2(NCHAN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cur_val,
    output state_e           state,
    output logic [IDXW-1:0]  ptr,
    output logic [TALW-1:0]  tally
);

    localparam logic [IDXW-1:0] LAST = IDXW'(NCHAN - 1);

    state_e           state_d;
    logic [WIDTH-1:0] expected;
    logic             mismatch;

    // Expected reset value for the channel under the pointer, and whether it drifted
    always_comb begin
        expected = WIDTH'(init_val(MAXW'(INITVAL), MAXW'(STRIDE), 32'(ptr), WIDTH));
        mismatch = (cur_val != expected);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: IDLE -> SWEEP on start, SWEEP -> DONE after the last channel
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state;
        case (state)
            ST_IDLE:  if (start) state_d = ST_SWEEP;
            ST_SWEEP: if (ptr == LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pointer and mismatch tally: cleared on start, advanced once per sweep cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            tally <= '0;
        end else if (state == ST_IDLE && start) begin
            ptr   <= '0;
            tally <= '0;
        end else if (state == ST_SWEEP) begin
            ptr   <= (ptr == LAST) ? '0 : ptr + IDXW'(1);
            tally <= tally + TALW'(mismatch);
        end
    end

endmodule

// File: rtl/glob_bank.sv
// Bank of NCHAN registers with a valid/ready command port (read, write,
// check, sweep), a saturating error counter, a cycle counter and
// hierarchically callable accessors for regression tops.
module glob_bank
    import glob_bank_pkg::*;
#(
    parameter int          NCHAN   = 4,
    parameter int          WIDTH   = 32,
    parameter logic [31:0] INITVAL = 32'hf00d,
    parameter int          STRIDE  = 1,
    localparam int         IDXW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int         TALW    = $clog2(NCHAN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDXW-1:0]  req_idx,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [ERRW-1:0]  err_count,
    output logic [31:0]      cyc
);

    logic [WIDTH-1:0] regs [NCHAN];

    state_e           state;
    logic [IDXW-1:0]  sweep_ptr;
    logic [TALW-1:0]  sweep_tally;
    logic             sweep_done;

    op_e              op;
    logic             accept;
    logic             is_cmd;
    logic             in_range;
    logic [WIDTH-1:0] cur_reg;
    logic             cmd_err;
    logic [ERRW-1:0]  err_inc;
    logic [ERRW:0]    err_sum;
    logic [ERRW-1:0]  err_next;

    logic             cmd_valid_q;
    logic [WIDTH-1:0] cmd_data_q;
    logic             cmd_err_q;

    glob_bank_sweep #(
        .NCHAN   (NCHAN),
        .WIDTH   (WIDTH),
        .INITVAL (INITVAL),
        .STRIDE  (STRIDE)
    ) u_sweep (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && op == OP_SWEEP),
        .cur_val (regs[sweep_ptr]),
        .state   (state),
        .ptr     (sweep_ptr),
        .tally   (sweep_tally)
    );

    assign req_ready  = (state == ST_IDLE);
    assign sweep_done = (state == ST_DONE);

    // Command decode: range check, selected register, error outcome
    always_comb begin
        op       = op_e'(req_op);
        accept   = req_valid && req_ready;
        is_cmd   = accept && (op != OP_SWEEP);
        in_range = (32'(req_idx) < NCHAN);
        cur_reg  = in_range ? regs[req_idx] : '0;
        cmd_err  = !in_range || (op == OP_CHECK && cur_reg != req_data);
    end

    // Register array: reset to per-channel init values, written by in-range WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset element by element because the sweep relies on known init values.
            for (int i = 0; i < NCHAN; i++) begin
                regs[i] <= WIDTH'(init_val(MAXW'(INITVAL), MAXW'(STRIDE), i, WIDTH));
            end
        end else if (is_cmd && op == OP_WRITE && in_range) begin
            regs[req_idx] <= req_data;
        end
    end

    // Command response registers: one-cycle pulse after READ/WRITE/CHECK acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_valid_q <= is_cmd;
            cmd_data_q  <= is_cmd ? cur_reg : '0;
            cmd_err_q   <= is_cmd && cmd_err;
        end
    end

    // Response mux: the sweep result owns the port while in DONE
    always_comb begin
        rsp_valid = sweep_done || cmd_valid_q;
        rsp_data  = sweep_done ? WIDTH'(sweep_tally) : cmd_data_q;
        rsp_err   = sweep_done ? (sweep_tally != '0) : cmd_err_q;
    end

    // Error increment and saturating sum; commands and DONE never coincide
    always_comb begin
        err_inc = '0;
        if (sweep_done) begin
            err_inc = ERRW'(sweep_tally);
        end else if (is_cmd && cmd_err) begin
            err_inc = ERRW'(1);
        end
        err_sum  = {1'b0, err_count} + {1'b0, err_inc};
        err_next = err_sum[ERRW] ? '1 : err_sum[ERRW-1:0];
    end

    // Error and cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            cyc       <= '0;
        end else begin
            err_count <= err_next;
            cyc       <= cyc + 32'd1;
        end
    end

    // Current value of channel idx, or 0 when idx is out of range.
    function automatic logic [WIDTH-1:0] getGlob(input int idx);
        if (idx < 0 || idx >= NCHAN) return '0;
        return regs[IDXW'(idx)];
    endfunction

    // Reset value of channel idx.
    function automatic logic [WIDTH-1:0] getInit(input int idx);
        return WIDTH'(init_val(MAXW'(INITVAL), MAXW'(STRIDE), idx, WIDTH));
    endfunction

    // Fixed identifier of this block type, as four ASCII characters.
    function automatic logic [31:0] getName(input int fake);
        logic [31:0] name;
        name = "gbnk";
        return (fake >= 0) ? name : name;
    endfunction

    // Halts simulation when channel idx does not hold val.
    task automatic checkGlob(input int idx, input logic [WIDTH-1:0] val);
        if (getGlob(idx) !== val) $stop;
    endtask

endmodule

// File: tb/tb_glob_bank.sv
// Self-checking bench for glob_bank: behavioural model with a per-cycle
// compare, randomized commands, and directed cases on a 3-channel instance.
module tb_glob_bank;
    import glob_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: NCHAN=4, INITVAL=f00d, STRIDE=1
    logic        rst, req_valid, req_ready, rsp_valid, rsp_err;
    logic [1:0]  req_op, req_idx;
    logic [31:0] req_data, rsp_data, cyc;
    logic [15:0] err_count;

    glob_bank dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_idx(req_idx), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_count(err_count), .cyc(cyc)
    );

    // Second DUT: NCHAN=3, INITVAL=f22d, STRIDE=2
    logic        rst3, r3_valid, r3_ready, r3_rsp_valid, r3_rsp_err;
    logic [1:0]  r3_op, r3_idx;
    logic [31:0] r3_data, r3_rsp_data, r3_cyc;
    logic [15:0] r3_err_count;

    glob_bank #(.NCHAN(3), .INITVAL(32'hf22d), .STRIDE(2)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(r3_valid), .req_ready(r3_ready),
        .req_op(r3_op), .req_idx(r3_idx), .req_data(r3_data),
        .rsp_valid(r3_rsp_valid), .rsp_data(r3_rsp_data), .rsp_err(r3_rsp_err),
        .err_count(r3_err_count), .cyc(r3_cyc)
    );

    // Two-element array of idle banks reached through dotted references
    for (genvar g = 0; g < 2; g++) begin : g_arr
        logic        a_ready, a_valid, a_err;
        logic [31:0] a_data, a_cyc;
        logic [15:0] a_errc;
        glob_bank #(.INITVAL(32'ha000 + 32'(g * 16))) u_bank (
            .clk(clk), .rst(rst), .req_valid(1'b0), .req_ready(a_ready),
            .req_op(2'd0), .req_idx(2'd0), .req_data(32'd0),
            .rsp_valid(a_valid), .rsp_data(a_data), .rsp_err(a_err),
            .err_count(a_errc), .cyc(a_cyc)
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main DUT ----------------
    logic [31:0] m_regs [4];
    int          m_err, m_tally, m_sweep_left;
    bit          m_done, m_valid, m_rerr;
    logic [31:0] m_data, m_cyc;
    bit          checking = 0;

    function automatic logic [31:0] init_of(input int i);
        return 32'hf00d + 32'(i);
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = init_of(i);
        m_err = 0; m_tally = 0; m_sweep_left = 0;
        m_done = 0; m_valid = 0; m_rerr = 0; m_data = 0; m_cyc = 0;
    endtask

    function automatic bit m_ready();
        return (m_sweep_left == 0) && !m_done;
    endfunction

    task automatic model_step();
        m_cyc = m_cyc + 32'd1;
        m_valid = 0;
        if (m_done) begin
            m_err  = sat16(m_err + m_tally);
            m_done = 0;
        end else if (m_sweep_left > 0) begin
            m_sweep_left--;
            if (m_sweep_left == 0) begin
                m_done  = 1;
                m_valid = 1;
                m_data  = 32'(m_tally);
                m_rerr  = (m_tally != 0);
            end
        end else if (req_valid) begin
            case (req_op)
                2'd0: begin m_valid = 1; m_data = m_regs[req_idx]; m_rerr = 0; end
                2'd1: begin m_valid = 1; m_data = m_regs[req_idx]; m_rerr = 0;
                            m_regs[req_idx] = req_data; end
                2'd2: begin m_valid = 1; m_data = m_regs[req_idx];
                            m_rerr = (m_regs[req_idx] != req_data);
                            if (m_rerr) m_err = sat16(m_err + 1); end
                default: begin
                    m_tally = 0;
                    for (int i = 0; i < 4; i++) if (m_regs[i] != init_of(i)) m_tally++;
                    m_sweep_left = 4;
                end
            endcase
        end
    endtask

    // Model advances on every active edge out of reset
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) model_step();
        end
    end

    // Compare process: DUT outputs against the model on every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("req_ready", req_ready, m_ready());
                check("rsp_valid", rsp_valid, m_valid);
                if (m_valid) begin
                    check("rsp_data", rsp_data, m_data);
                    check("rsp_err", rsp_err, m_rerr);
                end
                check("err_count", err_count, m_err);
                check("cyc", cyc, m_cyc);
                for (int i = 0; i < 4; i++) check("getGlob", dut.getGlob(i), m_regs[i]);
            end
        end
    end

    // Drives one command for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [1:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        req_valid = 1; req_op = op; req_idx = idx; req_data = data;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
    endtask

    task automatic issue3(input logic [1:0] op, input logic [1:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        r3_valid = 1; r3_op = op; r3_idx = idx; r3_data = data;
        @(posedge clk); #1;
        r3_valid = 0;
        @(negedge clk);
    endtask

    logic [31:0] name_exp;

    initial begin
        name_exp  = "gbnk";
        rst = 1; rst3 = 1;
        req_valid = 0; req_op = 0; req_idx = 0; req_data = 0;
        r3_valid = 0; r3_op = 0; r3_idx = 0; r3_data = 0;
        model_reset();
        #12;
        rst = 0; rst3 = 0;

        // Reset state, pinned with literals
        check("init0", dut.getGlob(0), 32'hf00d);
        check("init1", dut.getGlob(1), 32'hf00e);
        check("init2", dut.getGlob(2), 32'hf00f);
        check("init3", dut.getGlob(3), 32'hf010);
        check("reset_cyc", cyc, 0);
        check("reset_errc", err_count, 0);
        check("reset_ready", req_ready, 1);
        check("reset_rspv", rsp_valid, 0);
        checking = 1;

        // Directed WRITE/READ/CHECK
        issue(2'd1, 2'd2, 32'h1234);
        check("wr_valid", rsp_valid, 1);
        check("wr_old", rsp_data, 32'hf00f);
        check("wr_err", rsp_err, 0);
        issue(2'd0, 2'd2, 32'h0);
        check("rd_data", rsp_data, 32'h1234);
        check("rd_err", rsp_err, 0);
        issue(2'd2, 2'd1, 32'hf00e);
        check("chk_ok_err", rsp_err, 0);
        issue(2'd2, 2'd1, 32'h0);
        check("chk_bad_err", rsp_err, 1);
        check("chk_bad_errc", err_count, 1);

        // Directed sweep with one modified channel
        issue(2'd3, 2'd0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            check("sw_ready", req_ready, 0);
            check("sw_valid", rsp_valid, (k == 5));
            if (k == 5) begin
                check("sw_data", rsp_data, 1);
                check("sw_err", rsp_err, 1);
            end
            @(negedge clk);
        end
        check("sw_errc", err_count, 2);
        check("sw_ready_after", req_ready, 1);

        // Randomized traffic
        repeat (2000) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req_idx   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       req_data = $urandom;
                1:       req_data = init_of(int'(req_idx));
                default: req_data = m_regs[req_idx];
            endcase
        end
        @(posedge clk); #1;
        req_valid = 0;
        repeat (8) @(posedge clk);

        // Out-of-range on the 3-channel bank
        issue3(2'd0, 2'd3, 32'h0);
        check("oob_rd_valid", r3_rsp_valid, 1);
        check("oob_rd_data", r3_rsp_data, 0);
        check("oob_rd_err", r3_rsp_err, 1);
        check("oob_rd_errc", r3_err_count, 1);
        issue3(2'd1, 2'd3, 32'h55);
        check("oob_wr_data", r3_rsp_data, 0);
        check("oob_wr_err", r3_rsp_err, 1);
        check("oob_wr_errc", r3_err_count, 2);
        check("b3_ch0", dut3.getGlob(0), 32'hf22d);
        check("b3_ch1", dut3.getGlob(1), 32'hf22f);
        check("b3_ch2", dut3.getGlob(2), 32'hf231);
        check("b3_ch3", dut3.getGlob(3), 0);
        check("b3_init2", dut3.getInit(2), 32'hf231);
        check("name", dut3.getName(0), name_exp);
        check("name_main", dut.getName(1), name_exp);

        // 3-channel sweep after a write: response NCHAN+1 = 4 cycles after accept
        issue3(2'd1, 2'd1, 32'h0);
        check("b3_wr_old", r3_rsp_data, 32'hf22f);
        issue3(2'd3, 2'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            check("b3_sw_ready", r3_ready, 0);
            check("b3_sw_valid", r3_rsp_valid, (k == 4));
            if (k == 4) begin
                check("b3_sw_data", r3_rsp_data, 1);
                check("b3_sw_err", r3_rsp_err, 1);
            end
            @(negedge clk);
        end
        check("b3_sw_errc", r3_err_count, 3);

        // Reset in the middle of a sweep
        issue3(2'd3, 2'd0, 32'h0);
        @(posedge clk); #1;
        rst3 = 1;
        #1;
        check("mid_rst_valid", r3_rsp_valid, 0);
        check("mid_rst_ready", r3_ready, 1);
        check("mid_rst_cyc", r3_cyc, 0);
        check("mid_rst_errc", r3_err_count, 0);
        check("mid_rst_ch1", dut3.getGlob(1), 32'hf22f);
        #3;
        rst3 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_valid", r3_rsp_valid, 0);
            check("post_rst_ready", r3_ready, 1);
        end

        // Generate-array instances reached by dotted reference
        check("arr0", g_arr[0].u_bank.getGlob(0), 32'ha000);
        check("arr1", g_arr[1].u_bank.getGlob(0), 32'ha010);
        check("inst_main", dut.getInit(0), 32'hf00d);
        check("inst_b3", dut3.getGlob(0), 32'hf22d);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
